// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI write arbiter.
package axi_arb_pkg;

  localparam int unsigned AWID_W     = 4;
  localparam logic [1:0]  BRESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    AW_IDLE  = 1'b0,
    AW_ISSUE = 1'b1
  } aw_state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/arb_order_fifo.sv
// One-bit synchronous FIFO holding the requester index of each granted burst,
// so W data is forwarded in the same order the AW channel was issued.
module arb_order_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: two requesters onto one manager port.
// Define AXI_WR_ARBITER_STATS_EN to add burst and error-response counters.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned DW          = 512,
  parameter int unsigned ORDER_DEPTH = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [63:0]     S0_AXI_AWADDR,
  input  logic [7:0]      S0_AXI_AWLEN,
  input  logic [2:0]      S0_AXI_AWSIZE,
  input  logic [1:0]      S0_AXI_AWBURST,
  input  logic            S0_AXI_AWVALID,
  output logic            S0_AXI_AWREADY,
  input  logic [DW-1:0]   S0_AXI_WDATA,
  input  logic [DW/8-1:0] S0_AXI_WSTRB,
  input  logic            S0_AXI_WLAST,
  input  logic            S0_AXI_WVALID,
  output logic            S0_AXI_WREADY,
  output logic [1:0]      S0_AXI_BRESP,
  output logic            S0_AXI_BVALID,
  input  logic            S0_AXI_BREADY,
  input  logic [63:0]     S1_AXI_AWADDR,
  input  logic [7:0]      S1_AXI_AWLEN,
  input  logic [2:0]      S1_AXI_AWSIZE,
  input  logic [1:0]      S1_AXI_AWBURST,
  input  logic            S1_AXI_AWVALID,
  output logic            S1_AXI_AWREADY,
  input  logic [DW-1:0]   S1_AXI_WDATA,
  input  logic [DW/8-1:0] S1_AXI_WSTRB,
  input  logic            S1_AXI_WLAST,
  input  logic            S1_AXI_WVALID,
  output logic            S1_AXI_WREADY,
  output logic [1:0]      S1_AXI_BRESP,
  output logic            S1_AXI_BVALID,
  input  logic            S1_AXI_BREADY,
  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic [3:0]      M_AXI_AWID,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic [3:0]      M_AXI_BID,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY
`ifdef AXI_WR_ARBITER_STATS_EN
  ,
  output logic [31:0]     s0_bursts,
  output logic [31:0]     s1_bursts,
  output logic [31:0]     bresp_errors
`endif
);

  aw_state_e          state_q, state_d;
  req_idx_t           last_q, last_d;
  req_idx_t           gidx;
  logic               grant_c;
  logic               fifo_full, fifo_empty, fifo_head, fifo_pop;
  req_idx_t           w_sel;
  req_idx_t           b_sel;
  logic               unused_bid;
  logic [63:0]        aw_addr_q;
  logic [7:0]         aw_len_q;
  logic [2:0]         aw_size_q;
  logic [1:0]         aw_burst_q;
  logic [AWID_W-1:0]  aw_id_q;

  // Grant decision: the requester not granted last wins a tie.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    gidx           = ~last_q;
    grant_c        = 1'b0;
    S0_AXI_AWREADY = 1'b0;
    S1_AXI_AWREADY = 1'b0;
    case (state_q)
      AW_IDLE: begin
        if (resetn && (S0_AXI_AWVALID || S1_AXI_AWVALID) && !fifo_full) begin
          grant_c = 1'b1;
          if (!(S0_AXI_AWVALID && S1_AXI_AWVALID)) gidx = req_idx_t'(S1_AXI_AWVALID);
          last_d         = gidx;
          state_d        = AW_ISSUE;
          S0_AXI_AWREADY = ~gidx;
          S1_AXI_AWREADY = gidx;
        end
      end
      AW_ISSUE: if (M_AXI_AWREADY) state_d = AW_IDLE;
      default:  state_d = AW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= AW_IDLE;
      last_q     <= 1'b1;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_id_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (grant_c) begin
        aw_addr_q  <= gidx ? S1_AXI_AWADDR  : S0_AXI_AWADDR;
        aw_len_q   <= gidx ? S1_AXI_AWLEN   : S0_AXI_AWLEN;
        aw_size_q  <= gidx ? S1_AXI_AWSIZE  : S0_AXI_AWSIZE;
        aw_burst_q <= gidx ? S1_AXI_AWBURST : S0_AXI_AWBURST;
        aw_id_q    <= AWID_W'({3'b000, gidx});
      end
    end
  end

  assign M_AXI_AWVALID = (state_q == AW_ISSUE);
  assign M_AXI_AWADDR  = aw_addr_q;
  assign M_AXI_AWLEN   = aw_len_q;
  assign M_AXI_AWSIZE  = aw_size_q;
  assign M_AXI_AWBURST = aw_burst_q;
  assign M_AXI_AWID    = aw_id_q;

  arb_order_fifo #(.DEPTH(ORDER_DEPTH)) u_order (
    .clk    (clk),
    .resetn (resetn),
    .push   (grant_c),
    .din    (gidx),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // W path follows the oldest outstanding grant.
  assign w_sel         = fifo_head & ~fifo_empty;
  assign M_AXI_WDATA   = w_sel ? S1_AXI_WDATA : S0_AXI_WDATA;
  assign M_AXI_WSTRB   = w_sel ? S1_AXI_WSTRB : S0_AXI_WSTRB;
  assign M_AXI_WLAST   = w_sel ? S1_AXI_WLAST : S0_AXI_WLAST;
  assign M_AXI_WVALID  = ~fifo_empty & (w_sel ? S1_AXI_WVALID : S0_AXI_WVALID);
  assign S0_AXI_WREADY = ~fifo_empty & ~w_sel & M_AXI_WREADY;
  assign S1_AXI_WREADY = ~fifo_empty & w_sel & M_AXI_WREADY;
  assign fifo_pop      = M_AXI_WVALID & M_AXI_WREADY & M_AXI_WLAST;

  // B path is steered by the low bit of BID, which carries the requester index.
  assign b_sel         = M_AXI_BID[0];
  assign unused_bid    = ^M_AXI_BID[AWID_W-1:1];
  assign S0_AXI_BVALID = M_AXI_BVALID & ~b_sel;
  assign S1_AXI_BVALID = M_AXI_BVALID & b_sel;
  assign S0_AXI_BRESP  = M_AXI_BRESP;
  assign S1_AXI_BRESP  = M_AXI_BRESP;
  assign M_AXI_BREADY  = b_sel ? S1_AXI_BREADY : S0_AXI_BREADY;

`ifdef AXI_WR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_bursts    <= '0;
      s1_bursts    <= '0;
      bresp_errors <= '0;
    end else begin
      if (grant_c && !gidx) s0_bursts <= s0_bursts + 32'd1;
      if (grant_c && gidx)  s1_bursts <= s1_bursts + 32'd1;
      if (M_AXI_BVALID && M_AXI_BREADY && (M_AXI_BRESP != BRESP_OKAY))
        bresp_errors <= bresp_errors + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: requester and B-responder models live in
// tasks; each scenario task checks hand-computed expectations inline.
module tb_axi_wr_arbiter;

  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic [63:0] S0_AXI_AWADDR, S1_AXI_AWADDR, M_AXI_AWADDR;
  logic [7:0]  S0_AXI_AWLEN, S1_AXI_AWLEN, M_AXI_AWLEN;
  logic [2:0]  S0_AXI_AWSIZE, S1_AXI_AWSIZE, M_AXI_AWSIZE;
  logic [1:0]  S0_AXI_AWBURST, S1_AXI_AWBURST, M_AXI_AWBURST;
  logic        S0_AXI_AWVALID, S1_AXI_AWVALID, M_AXI_AWVALID;
  logic        S0_AXI_AWREADY, S1_AXI_AWREADY, M_AXI_AWREADY;
  logic [DW-1:0]   S0_AXI_WDATA, S1_AXI_WDATA, M_AXI_WDATA;
  logic [DW/8-1:0] S0_AXI_WSTRB, S1_AXI_WSTRB, M_AXI_WSTRB;
  logic        S0_AXI_WLAST, S1_AXI_WLAST, M_AXI_WLAST;
  logic        S0_AXI_WVALID, S1_AXI_WVALID, M_AXI_WVALID;
  logic        S0_AXI_WREADY, S1_AXI_WREADY, M_AXI_WREADY;
  logic [1:0]  S0_AXI_BRESP, S1_AXI_BRESP, M_AXI_BRESP;
  logic        S0_AXI_BVALID, S1_AXI_BVALID, M_AXI_BVALID;
  logic        S0_AXI_BREADY, S1_AXI_BREADY, M_AXI_BREADY;
  logic [3:0]  M_AXI_AWID, M_AXI_BID;
  logic [3:0]  M_AXI_BID_unused;
`ifdef AXI_WR_ARBITER_STATS_EN
  logic [31:0] s0_bursts, s1_bursts, bresp_errors;
`endif

  axi_wr_arbiter #(.DW(DW), .ORDER_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .S0_AXI_AWADDR(S0_AXI_AWADDR), .S0_AXI_AWLEN(S0_AXI_AWLEN), .S0_AXI_AWSIZE(S0_AXI_AWSIZE),
    .S0_AXI_AWBURST(S0_AXI_AWBURST), .S0_AXI_AWVALID(S0_AXI_AWVALID), .S0_AXI_AWREADY(S0_AXI_AWREADY),
    .S0_AXI_WDATA(S0_AXI_WDATA), .S0_AXI_WSTRB(S0_AXI_WSTRB), .S0_AXI_WLAST(S0_AXI_WLAST),
    .S0_AXI_WVALID(S0_AXI_WVALID), .S0_AXI_WREADY(S0_AXI_WREADY),
    .S0_AXI_BRESP(S0_AXI_BRESP), .S0_AXI_BVALID(S0_AXI_BVALID), .S0_AXI_BREADY(S0_AXI_BREADY),
    .S1_AXI_AWADDR(S1_AXI_AWADDR), .S1_AXI_AWLEN(S1_AXI_AWLEN), .S1_AXI_AWSIZE(S1_AXI_AWSIZE),
    .S1_AXI_AWBURST(S1_AXI_AWBURST), .S1_AXI_AWVALID(S1_AXI_AWVALID), .S1_AXI_AWREADY(S1_AXI_AWREADY),
    .S1_AXI_WDATA(S1_AXI_WDATA), .S1_AXI_WSTRB(S1_AXI_WSTRB), .S1_AXI_WLAST(S1_AXI_WLAST),
    .S1_AXI_WVALID(S1_AXI_WVALID), .S1_AXI_WREADY(S1_AXI_WREADY),
    .S1_AXI_BRESP(S1_AXI_BRESP), .S1_AXI_BVALID(S1_AXI_BVALID), .S1_AXI_BREADY(S1_AXI_BREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BID(M_AXI_BID), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
`ifdef AXI_WR_ARBITER_STATS_EN
    , .s0_bursts(s0_bursts), .s1_bursts(s1_bursts), .bresp_errors(bresp_errors)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Requester / responder model state
  int          aw_pend0, aw_pend1, w_pend0, w_pend1, w_beat0, w_beat1, len;
  logic [63:0] aw_addr0, aw_addr1;
  logic        m_awready, m_wready, s0_bready, s1_bready, b_manual;
  int          m_beats, b0_cnt, b1_cnt;
  int          grant_q[$];
  logic [63:0] maw_addr_q[$];
  int          maw_id_q[$];
  logic [7:0]  wsrc_q[$];
  bit          bq[$];

  task automatic drive();
    S0_AXI_AWVALID = (aw_pend0 > 0); S0_AXI_AWADDR = aw_addr0; S0_AXI_AWLEN = 8'(len);
    S0_AXI_AWSIZE = 3'd6; S0_AXI_AWBURST = 2'b01;
    S1_AXI_AWVALID = (aw_pend1 > 0); S1_AXI_AWADDR = aw_addr1; S1_AXI_AWLEN = 8'(len);
    S1_AXI_AWSIZE = 3'd6; S1_AXI_AWBURST = 2'b01;
    S0_AXI_WVALID = (w_pend0 > 0); S0_AXI_WLAST = (w_beat0 == len); S0_AXI_WSTRB = '1;
    S0_AXI_WDATA = '0; S0_AXI_WDATA[7:0] = 8'hA0; S0_AXI_WDATA[15:8] = 8'(w_beat0);
    S1_AXI_WVALID = (w_pend1 > 0); S1_AXI_WLAST = (w_beat1 == len); S1_AXI_WSTRB = '1;
    S1_AXI_WDATA = '0; S1_AXI_WDATA[7:0] = 8'hB1; S1_AXI_WDATA[15:8] = 8'(w_beat1);
    M_AXI_AWREADY = m_awready; M_AXI_WREADY = m_wready;
    S0_AXI_BREADY = s0_bready; S1_AXI_BREADY = s1_bready;
    if (!b_manual) begin
      M_AXI_BVALID = (bq.size() > 0);
      M_AXI_BID    = (bq.size() > 0 && bq[0]) ? 4'd1 : 4'd0;
      M_AXI_BRESP  = 2'b00;
    end
  endtask

  task automatic clear_model();
    aw_pend0 = 0; aw_pend1 = 0; w_pend0 = 0; w_pend1 = 0; w_beat0 = 0; w_beat1 = 0; len = 0;
    aw_addr0 = 64'h0; aw_addr1 = 64'h10000;
    m_awready = 1'b1; m_wready = 1'b1; s0_bready = 1'b1; s1_bready = 1'b1; b_manual = 1'b0;
    m_beats = 0; b0_cnt = 0; b1_cnt = 0;
    grant_q.delete(); maw_addr_q.delete(); maw_id_q.delete(); wsrc_q.delete(); bq.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_model();
    drive();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // One clock: record handshakes at the falling edge, advance the models after the rising edge.
  task automatic step();
    logic hs_aw0, hs_aw1, hs_w0, hs_w1, hs_b;
    @(negedge clk);
    hs_aw0 = S0_AXI_AWVALID && S0_AXI_AWREADY;
    hs_aw1 = S1_AXI_AWVALID && S1_AXI_AWREADY;
    hs_w0  = S0_AXI_WVALID && S0_AXI_WREADY;
    hs_w1  = S1_AXI_WVALID && S1_AXI_WREADY;
    hs_b   = M_AXI_BVALID && M_AXI_BREADY;
    if (hs_aw0) grant_q.push_back(0);
    if (hs_aw1) grant_q.push_back(1);
    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
      maw_addr_q.push_back(M_AXI_AWADDR);
      maw_id_q.push_back(int'(M_AXI_AWID));
    end
    if (M_AXI_WVALID && M_AXI_WREADY) begin
      m_beats++;
      if (M_AXI_WLAST) begin
        wsrc_q.push_back(M_AXI_WDATA[7:0]);
        if (!b_manual) bq.push_back(M_AXI_WDATA[7:0] == 8'hB1);
      end
    end
    if (S0_AXI_BVALID && S0_AXI_BREADY) b0_cnt++;
    if (S1_AXI_BVALID && S1_AXI_BREADY) b1_cnt++;
    @(posedge clk);
    #1;
    if (hs_aw0) begin aw_pend0--; aw_addr0 += 64'h400; end
    if (hs_aw1) begin aw_pend1--; aw_addr1 += 64'h400; end
    if (hs_w0) begin if (w_beat0 == len) begin w_beat0 = 0; w_pend0--; end else w_beat0++; end
    if (hs_w1) begin if (w_beat1 == len) begin w_beat1 = 0; w_pend1--; end else w_beat1++; end
    if (hs_b && !b_manual && bq.size() > 0) void'(bq.pop_front());
    drive();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_model();
    aw_pend0 = 1; aw_pend1 = 1; w_pend0 = 1; w_pend1 = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (S0_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL reset_s0_awready got=%0b want=0", S0_AXI_AWREADY); end
    checks++; if (S1_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL reset_s1_awready got=%0b want=0", S1_AXI_AWREADY); end
    checks++; if (M_AXI_AWVALID !== 1'b0) begin errors++; $display("FAIL reset_m_awvalid got=%0b want=0", M_AXI_AWVALID); end
    checks++; if (M_AXI_WVALID !== 1'b0) begin errors++; $display("FAIL reset_m_wvalid got=%0b want=0", M_AXI_WVALID); end
    checks++; if ({S0_AXI_WREADY, S1_AXI_WREADY} !== 2'b00) begin errors++; $display("FAIL reset_s_wready got=%b want=00", {S0_AXI_WREADY, S1_AXI_WREADY}); end
    checks++; if (M_AXI_AWADDR !== 64'h0 || M_AXI_AWID !== 4'h0 || M_AXI_AWLEN !== 8'h0) begin
      errors++; $display("FAIL reset_m_aw_fields got addr=%h id=%h len=%h want 0", M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWLEN); end
`ifdef AXI_WR_ARBITER_STATS_EN
    checks++; if (s0_bursts !== 32'd0 || s1_bursts !== 32'd0 || bresp_errors !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d/%0d want 0", s0_bursts, s1_bursts, bresp_errors); end
`endif
  endtask

  task automatic test_s0_only();
    logic [63:0] exp_addr [3];
    exp_addr[0] = 64'h0; exp_addr[1] = 64'h400; exp_addr[2] = 64'h800;
    do_reset();
    len = 15; aw_pend0 = 3; w_pend0 = 3;
    drive();
    #1;
    checks++; if (S0_AXI_AWREADY !== 1'b1 || M_AXI_AWVALID !== 1'b0) begin
      errors++; $display("FAIL s0_first_grant got awready=%0b m_awvalid=%0b want 1/0", S0_AXI_AWREADY, M_AXI_AWVALID); end
    step();
    #1;
    checks++; if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWLEN !== 8'd15 || S0_AXI_AWREADY !== 1'b0) begin
      errors++; $display("FAIL s0_issue_latency got valid=%0b len=%0d awready=%0b want 1/15/0", M_AXI_AWVALID, M_AXI_AWLEN, S0_AXI_AWREADY); end
    for (int i = 0; i < 400 && b0_cnt < 3; i++) step();
    checks++; if (b0_cnt != 3) begin errors++; $display("FAIL s0_b_count got=%0d want=3", b0_cnt); end
    checks++; if (b1_cnt != 0) begin errors++; $display("FAIL s0_b1_count got=%0d want=0", b1_cnt); end
    checks++; if (m_beats != 48) begin errors++; $display("FAIL s0_w_beats got=%0d want=48", m_beats); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= maw_addr_q.size() || maw_addr_q[i] !== exp_addr[i] || maw_id_q[i] != 0) begin
        errors++; $display("FAIL s0_aw_%0d got addr=%h id=%0d want addr=%h id=0", i,
                           (i < maw_addr_q.size()) ? maw_addr_q[i] : 64'hx, (i < maw_id_q.size()) ? maw_id_q[i] : -1, exp_addr[i]);
      end
    end
`ifdef AXI_WR_ARBITER_STATS_EN
    checks++; if (s0_bursts !== 32'd3 || s1_bursts !== 32'd0) begin
      errors++; $display("FAIL s0_stats got %0d/%0d want 3/0", s0_bursts, s1_bursts); end
`endif
  endtask

  task automatic test_round_robin();
    int         exp_g [4];
    logic [7:0] exp_w [4];
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
    exp_w[0] = 8'hA0; exp_w[1] = 8'hB1; exp_w[2] = 8'hA0; exp_w[3] = 8'hB1;
    do_reset();
    len = 3; aw_pend0 = 2; aw_pend1 = 2; w_pend0 = 2; w_pend1 = 2;
    drive();
    for (int i = 0; i < 200 && (b0_cnt + b1_cnt) < 4; i++) step();
    checks++; if (b0_cnt != 2 || b1_cnt != 2) begin errors++; $display("FAIL rr_b_counts got %0d/%0d want 2/2", b0_cnt, b1_cnt); end
    checks++; if (m_beats != 16) begin errors++; $display("FAIL rr_w_beats got=%0d want=16", m_beats); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grant_q.size() || grant_q[i] != exp_g[i] || maw_id_q[i] != exp_g[i]) begin
        errors++; $display("FAIL rr_grant_%0d got=%0d awid=%0d want=%0d", i,
                           (i < grant_q.size()) ? grant_q[i] : -1, (i < maw_id_q.size()) ? maw_id_q[i] : -1, exp_g[i]);
      end
      checks++;
      if (i >= wsrc_q.size() || wsrc_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL rr_w_order_%0d got=%h want=%h", i, (i < wsrc_q.size()) ? wsrc_q[i] : 8'hxx, exp_w[i]);
      end
    end
`ifdef AXI_WR_ARBITER_STATS_EN
    checks++; if (s0_bursts !== 32'd2 || s1_bursts !== 32'd2) begin
      errors++; $display("FAIL rr_stats got %0d/%0d want 2/2", s0_bursts, s1_bursts); end
`endif
  endtask

  task automatic test_aw_stall();
    int          bad;
    int          exp_g [4];
    logic [63:0] exp_a [4];
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
    exp_a[0] = 64'h0; exp_a[1] = 64'h10000; exp_a[2] = 64'h400; exp_a[3] = 64'h10400;
    do_reset();
    m_awready = 1'b0; len = 7; aw_pend0 = 2; aw_pend1 = 2;
    drive();
    step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 64'h0 || M_AXI_AWID !== 4'h0 || M_AXI_AWLEN !== 8'd7) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_aw_stable got %0d unstable cycles want 0", bad); end
    checks++; if (grant_q.size() != 1) begin errors++; $display("FAIL stall_grant_count got=%0d want=1", grant_q.size()); end
    m_awready = 1'b1;
    drive();
    for (int i = 0; i < 40 && maw_addr_q.size() < 4; i++) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grant_q.size() || grant_q[i] != exp_g[i] || i >= maw_addr_q.size() || maw_addr_q[i] !== exp_a[i]) begin
        errors++; $display("FAIL stall_release_%0d got grant=%0d addr=%h want grant=%0d addr=%h", i,
                           (i < grant_q.size()) ? grant_q[i] : -1, (i < maw_addr_q.size()) ? maw_addr_q[i] : 64'hx, exp_g[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int pre;
    int pre_at_grant;
    do_reset();
    m_wready = 1'b0; len = 1; aw_pend0 = 9; w_pend0 = 9;
    drive();
    repeat (30) step();
    #1;
    checks++; if (grant_q.size() != 8) begin errors++; $display("FAIL full_grants got=%0d want=8", grant_q.size()); end
    checks++; if (S0_AXI_AWREADY !== 1'b0 || M_AXI_AWVALID !== 1'b0) begin
      errors++; $display("FAIL full_blocked got awready=%0b m_awvalid=%0b want 0/0", S0_AXI_AWREADY, M_AXI_AWVALID); end
    checks++; if (M_AXI_WVALID !== 1'b1 || S0_AXI_WREADY !== 1'b0) begin
      errors++; $display("FAIL full_w_stalled got wvalid=%0b wready=%0b want 1/0", M_AXI_WVALID, S0_AXI_WREADY); end
    m_wready = 1'b1;
    drive();
    pre_at_grant = -1;
    for (int i = 0; i < 40 && grant_q.size() < 9; i++) begin
      pre = wsrc_q.size();
      step();
      if (grant_q.size() == 9) pre_at_grant = pre;
    end
    checks++; if (grant_q.size() != 9) begin errors++; $display("FAIL full_ninth_grant got=%0d grants want=9", grant_q.size()); end
    checks++; if (pre_at_grant < 1) begin errors++; $display("FAIL full_grant_after_pop got pops_before=%0d want>=1", pre_at_grant); end
  endtask

  task automatic test_bresp_route();
    do_reset();
    b_manual = 1'b1; s0_bready = 1'b0; s1_bready = 1'b1;
    drive();
    M_AXI_BVALID = 1'b1; M_AXI_BID = 4'd1; M_AXI_BRESP = 2'b10;
    #1;
    checks++; if ({S0_AXI_BVALID, S1_AXI_BVALID} !== 2'b01) begin
      errors++; $display("FAIL b_route_id1 got s0/s1=%b want=01", {S0_AXI_BVALID, S1_AXI_BVALID}); end
    checks++; if (S1_AXI_BRESP !== 2'b10 || M_AXI_BREADY !== 1'b1) begin
      errors++; $display("FAIL b_resp_ready_id1 got resp=%b bready=%0b want 10/1", S1_AXI_BRESP, M_AXI_BREADY); end
    step();
    M_AXI_BID = 4'd0;
    #1;
`ifdef AXI_WR_ARBITER_STATS_EN
    checks++; if (bresp_errors !== 32'd1) begin errors++; $display("FAIL b_stats_errors got=%0d want=1", bresp_errors); end
`endif
    checks++; if ({S0_AXI_BVALID, S1_AXI_BVALID} !== 2'b10 || M_AXI_BREADY !== 1'b0 || S0_AXI_BRESP !== 2'b10) begin
      errors++; $display("FAIL b_route_id0 got s0/s1=%b bready=%0b resp=%b want 10/0/10",
                         {S0_AXI_BVALID, S1_AXI_BVALID}, M_AXI_BREADY, S0_AXI_BRESP); end
    M_AXI_BVALID = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    len = 15; aw_pend0 = 1; w_pend0 = 1;
    drive();
    for (int i = 0; i < 40 && m_beats < 5; i++) step();
    checks++; if (m_beats != 5) begin errors++; $display("FAIL midrst_reach_beat5 got=%0d want=5", m_beats); end
    resetn = 1'b0;
    #1;
    checks++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0 || S0_AXI_WREADY !== 1'b0 || M_AXI_AWADDR !== 64'h0) begin
      errors++; $display("FAIL midrst_outputs got awvalid=%0b wvalid=%0b wready=%0b addr=%h want 0", M_AXI_AWVALID,
                         M_AXI_WVALID, S0_AXI_WREADY, M_AXI_AWADDR); end
`ifdef AXI_WR_ARBITER_STATS_EN
    checks++; if (s0_bursts !== 32'd0) begin errors++; $display("FAIL midrst_stats got=%0d want=0", s0_bursts); end
`endif
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    aw_pend0 = 1; aw_pend1 = 1;
    drive();
    for (int i = 0; i < 10 && grant_q.size() < 1; i++) step();
    checks++; if (grant_q.size() < 1 || grant_q[0] != 0) begin
      errors++; $display("FAIL midrst_first_grant got=%0d want=0", (grant_q.size() > 0) ? grant_q[0] : -1); end
  endtask

  initial begin
    M_AXI_BVALID = 1'b0; M_AXI_BID = 4'd0; M_AXI_BRESP = 2'b00;
    M_AXI_BID_unused = 4'd0;
    test_reset();
    test_s0_only();
    test_round_robin();
    test_aw_stall();
    test_fifo_full();
    test_bresp_route();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
